// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS front end.
// Entry layout used between fetch storage and decode.
package mips_pkg;

  localparam int          INSTR_W      = 32;
  localparam logic [31:0] PC_STEP      = 32'd4;
  localparam logic [31:0] RESET_VECTOR = 32'h0000_0000;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [31:0]        pc4;
  } fq_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small circular buffer of fetched {instr, pc4} entries.
// Ports: clk, rst_n, push, pop, flush, wdata -> rdata, valid, count.
module fetch_fifo
  import mips_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  fq_entry_t              wdata,
  output fq_entry_t              rdata,
  output logic                   valid,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  fq_entry_t         mem [DEPTH];
  logic [PW-1:0]     rd_ptr;
  logic [PW-1:0]     wr_ptr;

  assign valid = (count != '0);
  // Empty head reads as zero so the reset view is all-zero.
  assign rdata = valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem[wr_ptr] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      unique case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fetch_queue.sv
// Fetch stage: PC register, imem drive, redirect and decode FIFO.
// Ports: clk, rst_n, imem_*, redirect_*, id_* handshake, q_count.
module fetch_queue
  import mips_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = RESET_VECTOR
) (
  input  logic                   clk,
  input  logic                   rst_n,
  output logic [31:0]            imem_addr,
  input  logic [INSTR_W-1:0]     imem_data,
  input  logic                   redirect_valid,
  input  logic [31:0]            redirect_pc,
  output logic                   id_valid,
  input  logic                   id_ready,
  output logic [INSTR_W-1:0]     id_instr,
  output logic [31:0]            id_pc4,
  output logic [$clog2(DEPTH):0] q_count
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [31:0] pc;
  logic [31:0] pc_nxt;
  logic [31:0] pc4;
  logic        pop;
  logic        push;
  logic        full;
  fq_entry_t   wdata;
  fq_entry_t   head;

  assign imem_addr = pc;
  assign pc4       = pc + PC_STEP;
  assign full      = (q_count == CW'(DEPTH));
  assign pop       = id_valid & id_ready;
  // A pop frees the slot being written this edge.
  assign push      = !redirect_valid & (!full | pop);

  assign wdata.instr = imem_data;
  assign wdata.pc4   = pc4;

  assign id_instr = head.instr;
  assign id_pc4   = head.pc4;

  always_comb begin
    pc_nxt = pc;
    unique case (1'b1)
      redirect_valid: pc_nxt = {redirect_pc[31:2], 2'b00};
      push:           pc_nxt = pc4;
      default:        pc_nxt = pc;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= RESET_PC;
    end else begin
      pc <= pc_nxt;
    end
  end

  fetch_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .flush (redirect_valid),
    .wdata (wdata),
    .rdata (head),
    .valid (id_valid),
    .count (q_count)
  );

endmodule
